// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the multiply/divide unit.
//   ITER / CNT_W : number of radix-2 iterations and width of the step counter
//   op_e         : operation codes (bit1 = signed, bit0 = divide)
//   state_e      : controller states
//   mag32()      : magnitude of a 32-bit operand, two's complement if signed
package muldiv_unit_pkg;

  localparam int ITER  = 32;
  localparam int CNT_W = 5;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_DIVU  = 2'b01,
    OP_MULT  = 2'b10,
    OP_DIV   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_e;

  function automatic logic [31:0] mag32(input logic [31:0] v, input logic signed_op);
    return (signed_op && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// 33-bit adder/subtractor used by both the shift-add multiply and the
// restoring divide iterations.
//   a_i, b_i : operands
//   sub_i    : 1 = a - b, 0 = a + b
//   sum_o    : 33-bit result
//   carry_o  : carry out; on subtract, 1 means no borrow (a >= b)
module muldiv_step (
  input  logic [32:0] a_i,
  input  logic [32:0] b_i,
  input  logic        sub_i,
  output logic [32:0] sum_o,
  output logic        carry_o
);

  logic [33:0] full;

  assign full    = {1'b0, a_i} + {1'b0, (sub_i ? ~b_i : b_i)} + {33'd0, sub_i};
  assign sum_o   = full[32:0];
  assign carry_o = full[33];

endmodule

// File: rtl/muldiv_unit.sv
// Iterative 32x32 multiply / 32/32 divide, signed and unsigned.
//   clk_i, rst_i     : clock, synchronous active-high reset
//   start_i, op_i    : request and operation code (sampled while not busy)
//   in1_i, in2_i     : multiplicand/dividend, multiplier/divisor
//   busy_o           : operation in progress
//   done_o           : one-cycle pulse when hi_o/lo_o are updated
//   hi_o, lo_o       : product[63:32]/[31:0] or remainder/quotient
//   div_by_zero_o    : last divide had a zero divisor (held until next done)
//
// state  | meaning
// IDLE   | waiting for start
// CALC   | one radix-2 step per cycle, ITER cycles
// FIX    | cycle 0: sign-correct in place; cycle 1: publish result
// DONE   | done pulse; a start here chains straight into CALC
module muldiv_unit
  import muldiv_unit_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [1:0]  op_i,
  input  logic [31:0] in1_i,
  input  logic [31:0] in2_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        div_by_zero_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(ITER - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             is_div_q, neg_q, neg_rem_q, dz_q;
  // acc_q: product high half / partial remainder
  // sh_q : multiplier shifting out / dividend shifting out, quotient shifting in
  logic [31:0]      acc_q, sh_q, opb_q;
  logic [31:0]      hi_q, lo_q;
  logic             busy_q, done_q, dbz_q;

  logic [31:0] a_mag, b_mag;
  logic [32:0] step_a, step_b, step_sum;
  logic        step_carry;
  logic [63:0] prod_neg;
  logic [31:0] acc_neg, sh_neg;

  assign a_mag    = mag32(in1_i, op_i[1]);
  assign b_mag    = mag32(in2_i, op_i[1]);
  assign prod_neg = ~{acc_q, sh_q} + 64'd1;
  assign acc_neg  = ~acc_q + 32'd1;
  assign sh_neg   = ~sh_q + 32'd1;

  always_comb begin
    if (is_div_q) begin
      step_a = {acc_q, sh_q[31]};
      step_b = {1'b0, opb_q};
    end else begin
      step_a = {1'b0, acc_q};
      step_b = sh_q[0] ? {1'b0, opb_q} : 33'd0;
    end
  end

  muldiv_step u_step (
    .a_i     (step_a),
    .b_i     (step_b),
    .sub_i   (is_div_q),
    .sum_o   (step_sum),
    .carry_o (step_carry)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      dbz_q     <= 1'b0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      acc_q     <= '0;
      sh_q      <= '0;
      opb_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
          if (start_i) begin
            state_q   <= S_CALC;
            busy_q    <= 1'b1;
            cnt_q     <= '0;
            is_div_q  <= op_i[0];
            neg_q     <= op_i[1] & (in1_i[31] ^ in2_i[31]);
            neg_rem_q <= op_i[1] & op_i[0] & in1_i[31];
            dz_q      <= op_i[0] & (in2_i == 32'd0);
            acc_q     <= '0;
            sh_q      <= op_i[0] ? a_mag : b_mag;
            opb_q     <= op_i[0] ? b_mag : a_mag;
          end
        end
        S_CALC: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) state_q <= S_FIX;
          if (is_div_q) begin
            // Restoring step: keep the difference only when it did not borrow.
            // A zero divisor never borrows, so the remainder ends up holding the
            // dividend magnitude -- exactly what the zero-divide result needs.
            acc_q <= step_carry ? step_sum[31:0] : step_a[31:0];
            sh_q  <= {sh_q[30:0], step_carry};
          end else begin
            acc_q <= step_sum[32:1];
            sh_q  <= {step_sum[0], sh_q[31:1]};
          end
        end
        S_FIX: begin
          if (cnt_q == '0) begin
            // Negation is done in place here so it stays off the output path.
            cnt_q <= CNT_W'(1);
            if (is_div_q) begin
              if (neg_q)     sh_q  <= sh_neg;
              if (neg_rem_q) acc_q <= acc_neg;
            end else if (neg_q) begin
              {acc_q, sh_q} <= prod_neg;
            end
          end else begin
            hi_q    <= acc_q;
            lo_q    <= dz_q ? 32'hFFFF_FFFF : sh_q;
            dbz_q   <= dz_q;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_DONE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign hi_o          = hi_q;
  assign lo_o          = lo_q;
  assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i, start_i;
  logic [1:0]  op_i;
  logic [31:0] in1_i, in2_i;
  logic        busy_o, done_o, div_by_zero_o;
  logic [31:0] hi_o, lo_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  muldiv_unit dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .start_i       (start_i),
    .op_i          (op_i),
    .in1_i         (in1_i),
    .in2_i         (in2_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .hi_o          (hi_o),
    .lo_o          (lo_o),
    .div_by_zero_o (div_by_zero_o)
  );

  typedef struct {
    string       name;
    op_e         op;
    logic [31:0] a, b, hi, lo;
    logic        dz;
  } vec_t;

  localparam int NVEC = 16;
  vec_t vecs[NVEC];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Present a request for one edge, then scramble the operand inputs.
  task automatic issue(input op_e op, input logic [31:0] a, input logic [31:0] b);
    start_i = 1'b1;
    op_i    = op;
    in1_i   = a;
    in2_i   = b;
    tick();
    start_i = 1'b0;
    op_i    = 2'($urandom);
    in1_i   = $urandom;
    in2_i   = $urandom;
  endtask

  task automatic wait_done(input int base, output int lat);
    lat = base;
    while (!done_o && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  task automatic check_result(input string name, input int lat, input logic [31:0] hi,
                              input logic [31:0] lo, input logic dz);
    chk({name, ".lat"},  lat, 34);
    chk({name, ".done"}, done_o, 1'b1);
    chk({name, ".busy"}, busy_o, 1'b0);
    chk({name, ".hi"},   hi_o, hi);
    chk({name, ".lo"},   lo_o, lo);
    chk({name, ".dz"},   div_by_zero_o, dz);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    int dcnt;

    rst_i = 1'b1; start_i = 1'b0; op_i = '0; in1_i = '0; in2_i = '0;

    vecs[0]  = '{"multu_max",   OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[1]  = '{"mult_neg",    OP_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0};
    vecs[2]  = '{"div_neg",     OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[3]  = '{"divu_100_7",  OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
    vecs[4]  = '{"divu_zero",   OP_DIVU,  32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF, 1'b1};
    vecs[5]  = '{"multu_2_3",   OP_MULTU, 32'd2,        32'd3,        32'd0,        32'd6,        1'b0};
    vecs[6]  = '{"div_ovf",     OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[7]  = '{"div_neg_z",   OP_DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1};
    vecs[8]  = '{"div_7_m2",    OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
    vecs[9]  = '{"mult_min",    OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    vecs[10] = '{"multu_shift", OP_MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0};
    vecs[11] = '{"divu_by1",    OP_DIVU,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 1'b0};
    vecs[12] = '{"mult_zero",   OP_MULT,  32'h00000000, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 1'b0};
    vecs[13] = '{"div_min_2",   OP_DIV,   32'h80000000, 32'h00000002, 32'h00000000, 32'hC0000000, 1'b0};
    vecs[14] = '{"divu_small",  OP_DIVU,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 1'b0};
    vecs[15] = '{"mult_m1_m1",  OP_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};

    repeat (3) tick();
    chk("rst.busy", busy_o, 1'b0);
    chk("rst.done", done_o, 1'b0);
    chk("rst.hi",   hi_o, 32'h0);
    chk("rst.lo",   lo_o, 32'h0);
    chk("rst.dz",   div_by_zero_o, 1'b0);
    rst_i = 1'b0;
    tick();
    chk("idle.busy", busy_o, 1'b0);

    for (int i = 0; i < NVEC; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      chk({vecs[i].name, ".busy_on"}, busy_o, 1'b1);
      wait_done(0, lat);
      check_result(vecs[i].name, lat, vecs[i].hi, vecs[i].lo, vecs[i].dz);
      tick();
      chk({vecs[i].name, ".pulse"},   done_o, 1'b0);
      chk({vecs[i].name, ".hold_hi"}, hi_o, vecs[i].hi);
      chk({vecs[i].name, ".hold_lo"}, lo_o, vecs[i].lo);
    end

    // Back-to-back: a start in the DONE cycle chains directly.
    issue(OP_MULTU, 32'd7, 32'd9);
    wait_done(0, lat);
    check_result("b2b_a", lat, 32'd0, 32'd63, 1'b0);
    issue(OP_DIVU, 32'd100, 32'd7);
    chk("b2b_b.busy_on", busy_o, 1'b1);
    wait_done(0, lat);
    check_result("b2b_b", lat, 32'd2, 32'd14, 1'b0);
    tick();

    // A start pulse while busy must not disturb the running operation.
    issue(OP_MULTU, 32'd5, 32'd7);
    repeat (4) tick();
    start_i = 1'b1; op_i = OP_DIVU; in1_i = 32'd9; in2_i = 32'd0;
    tick();
    start_i = 1'b0;
    chk("ignored.busy", busy_o, 1'b1);
    wait_done(5, lat);
    check_result("ignored", lat, 32'd0, 32'd35, 1'b0);
    tick();

    // Leave the flag set, then abort a multiply with reset mid-flight.
    issue(OP_DIVU, 32'h64, 32'h0);
    wait_done(0, lat);
    check_result("pre_rst", lat, 32'h64, 32'hFFFFFFFF, 1'b1);
    tick();
    issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (4) tick();
    start_i = 1'b1; op_i = OP_DIV; in1_i = 32'd50; in2_i = 32'd5;
    tick();
    start_i = 1'b0;
    repeat (4) tick();
    rst_i = 1'b1;
    tick();
    chk("abort.busy", busy_o, 1'b0);
    chk("abort.done", done_o, 1'b0);
    chk("abort.hi",   hi_o, 32'h0);
    chk("abort.lo",   lo_o, 32'h0);
    chk("abort.dz",   div_by_zero_o, 1'b0);
    start_i = 1'b1; op_i = OP_MULTU; in1_i = 32'd3; in2_i = 32'd3;
    tick();
    rst_i = 1'b0; start_i = 1'b0;
    chk("rst_start.busy", busy_o, 1'b0);
    dcnt = 0;
    repeat (40) begin
      tick();
      if (done_o) dcnt++;
    end
    chk("abort.no_done", dcnt, 0);
    chk("abort.idle",    busy_o, 1'b0);
    issue(OP_MULTU, 32'd2, 32'd3);
    wait_done(0, lat);
    check_result("post_rst", lat, 32'd0, 32'd6, 1'b0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameters: none; operand and result width is fixed at 32 bits.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 start  in  1  request; sampled only while busy=0.
REQ-005 op  in  2  bit1 = signed, bit0 = divide: 00 MULTU, 01 DIVU, 10 MULT, 11 DIV (equals ALU control[1:0] for codes 1100-1111).
REQ-006 in1  in  32  rs operand (multiplicand/dividend).
REQ-007 in2  in  32  rt operand (multiplier/divisor).
REQ-008 busy  out  1  operation in progress.
REQ-009 done  out  1  single-cycle pulse; hi/lo valid and newly updated.
REQ-010 hi  out  32  product[63:32] or remainder.
REQ-011 lo  out  32  product[31:0] or quotient.
REQ-012 div_by_zero  out  1  set with done when divide op had in2=0; held until next done.

Function
REQ-013 States SHALL be IDLE, CALC, FIX, DONE.
REQ-014 IDLE or DONE with start=1: latch op, in1, in2 (magnitudes if op[1]=1, plus result-sign bits), clear 5-bit counter, go to CALC, busy=1 from next cycle.
REQ-015 CALC: one radix-2 step per cycle (shift-add multiply / restoring divide on 32-bit magnitudes); 32 cycles, then FIX.
REQ-016 FIX: apply sign correction, write hi/lo/div_by_zero, go to DONE.
REQ-017 DONE: done=1, busy=0 for exactly one cycle; next state CALC if start=1, else IDLE.
REQ-018 Latency: start sampled at edge N -> done high in cycle after edge N+34; back-to-back starts give 35-cycle throughput.
REQ-019 start while busy=1 SHALL be ignored with no effect on latched operands.
REQ-020 hi/lo SHALL hold last result between operations; operand inputs ignored outside the sampling edge.
REQ-021 Signed multiply: 64-bit product negated when operand signs differ.
REQ-022 Signed divide: quotient truncates toward zero; remainder takes dividend sign.
REQ-023 Divide by zero (any divide op): same latency; lo=0xFFFFFFFF, hi=in1 unmodified, div_by_zero=1.
REQ-024 DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0, no flag.
REQ-025 Multiply ops SHALL clear div_by_zero at their done.

Reset
REQ-026 rst=1 at any edge: state IDLE, counter 0, busy=0, done=0, hi=0, lo=0, div_by_zero=0.
REQ-027 rst mid-operation SHALL abort with no done pulse; start during rst is ignored.

Structure
REQ-028 Shared package SHALL hold the op encodings, state enum, and ITER=32 constant.
REQ-029 One sub-module, muldiv_step (33-bit add/subtract with carry/borrow out), SHALL be shared by multiply and divide iterations.

Verification
REQ-030 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001, done exactly 34 cycles after the start edge.
REQ-031 MULT 0xFFFFFFFD x 0x00000005 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
REQ-032 DIV 0xFFFFFFF9 / 0x00000002 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 100/7 -> lo=14, hi=2.
REQ-033 DIVU 0x64 / 0 -> lo=0xFFFFFFFF, hi=0x64, div_by_zero=1; following MULTU 2x3 -> lo=6, div_by_zero=0.
REQ-034 DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-035 Start MULTU, pulse start with new operands at cycle 5, assert rst at cycle 10 -> busy=0 next cycle, hi=lo=0, no done; a subsequent start then completes normally.
